alien_formation_ctrl: RTL and testbench
=======================================

ALIEN_FORMATION_CTRL -- requirements
Module: alien_formation_ctrl

Interface
REQ-001 SHALL have these parameters, all defaulting to shared-package constants: ROWS=4 (formation rows); COLS=8 (formation columns); STEP_PX=2 (horizontal pixels per march step); DROP_PX=16 (vertical pixels per edge drop).
REQ-002 SHALL have these ports:
- pixel_clk  in  1  clock
- rst  in  1  reset: synchronous, active-high, clocked by pixel_clk
- fsync  in  1  one-cycle frame-start pulse
- start  in  1  begin or restart a wave
- freeze  in  1  hold motion, e.g. pause or player death
- alive_mask  in  ROWS*COLS  per-alien alive flags; bit index is row*COLS+col
- group_lhpos  out  12 signed  formation left x
- group_tvpos  out  12 signed  formation top y
- speed  out  8  current step period, in frames
- dir_right  out  1  march direction, 1 = right
- alive_count  out  6  registered popcount of alive_mask
- wave_clear  out  1  formation destroyed
- invaded  out  1  formation reached the invasion line

Function
REQ-003 SHALL implement FSM states: IDLE, MARCH, DROP, CLEARED, INVADED.
REQ-004 SHALL sample alive_mask, start and freeze, and update every output register, only in the cycle where fsync=1; all outputs SHALL change exactly one cycle after that fsync and SHALL stay stable for the rest of the frame.
REQ-005 IDLE, start=1: group_lhpos=START_X (64), group_tvpos=START_Y (48), dir_right=1, frame counter=0 -> MARCH.
REQ-006 SHALL compute speed = 1 + (alive_count>>2), giving a range of 1..9 frames for a 32-alien formation.
REQ-007 MARCH: frame counter SHALL increment on each fsync with freeze=0; when the counter reaches speed-1 it SHALL clear and a step tick SHALL occur.
REQ-008 SHALL derive lcol/rcol as the lowest/highest column containing any alive bit, and brow as the highest row containing any alive bit.
REQ-009 SHALL use pitch values PX=ENEMY_W+SPACING_X (48) and PY=ENEMY_H+SPACING_Y (40).
REQ-010 SHALL compute the right edge as group_lhpos+rcol*PX+ENEMY_W-1 and the left edge as group_lhpos+lcol*PX.
REQ-011 On a step tick with dir_right=1: if right edge+STEP_PX > SCREEN_W-1-EDGE_MARGIN (623) -> DROP; else group_lhpos += STEP_PX.
REQ-012 On a step tick with dir_right=0: if left edge-STEP_PX < EDGE_MARGIN (16) -> DROP; else group_lhpos -= STEP_PX.
REQ-013 DROP: on the next fsync, group_tvpos += DROP_PX, dir_right SHALL toggle, group_lhpos SHALL be unchanged, and the FSM -> MARCH; the frame counter SHALL be cleared.
REQ-014 In MARCH, if group_tvpos+brow*PY+ENEMY_H-1 >= INVADE_Y (400) at an fsync: -> INVADED, with invaded=1 held.
REQ-015 If alive_count==0 at an fsync in MARCH or DROP: -> CLEARED, with wave_clear=1 held.
REQ-016 Priority at one fsync SHALL be: CLEARED > INVADED > DROP/step.
REQ-017 freeze=1 SHALL hold the counter, position, direction and state; alive_count SHALL still update.
REQ-018 CLEARED or INVADED with start=1: re-initialise as in REQ-005, clear the flags -> MARCH.
REQ-019 start in MARCH/DROP SHALL be ignored.
REQ-020 All edge arithmetic SHALL be 13-bit signed so that negative and overflow intermediates compare correctly.
REQ-021 Column/row products SHALL use constant multipliers only.

Reset
REQ-022 rst SHALL win over fsync in the same cycle.
REQ-023 rst SHALL abort any state mid-wave.
REQ-024 On rst, outputs SHALL take these values:
- state=IDLE
- group_lhpos=64
- group_tvpos=48
- dir_right=1
- frame counter=0
- alive_count=0
- speed=1
- wave_clear=0
- invaded=0

Structure
REQ-025 The shared params package SHALL hold: ENEMY_W, ENEMY_H, SPACING_X, SPACING_Y, SCREEN_W, START_X, START_Y, EDGE_MARGIN, INVADE_Y, ROWS, COLS, and a formation_state_t enum.
REQ-026 One combinational sub-module, alien_extent, SHALL produce lcol, rcol, brow, any_alive and popcount from alive_mask.
REQ-027 The FSM, counters and position registers SHALL live in alien_formation_ctrl.

Verification
REQ-028 Full mask, start, then 9 fsyncs -> group_lhpos=66 one cycle after the 9th fsync; speed=9.
REQ-029 Full mask, march right -> 96 steps leave the right edge at 623; the next tick enters DROP; the following fsync gives group_tvpos=64 and dir_right=0.
REQ-030 Only column 7 alive (rows 0-3) -> rcol=7, speed=2; after a drop and reversal, the left limit is based on lcol=7 with no early drop.
REQ-031 alive_mask to 0 on the same fsync as a step tick -> CLEARED, wave_clear=1, position unchanged; start -> MARCH with position 64/48.
REQ-032 Only row 0 alive, drops forced until top+23 >= 400 -> INVADED, invaded=1; rst mid-MARCH -> all reset values next cycle.
REQ-033 freeze=1 for 20 fsyncs mid-march -> position and counter unchanged, alive_count tracks the mask; motion resumes exactly where it stopped.

Source files
------------

// File: rtl/alien_formation_ctrl_pkg.sv
// Shared geometry constants and state encoding for the alien formation controller.
package alien_formation_ctrl_pkg;

    localparam int ENEMY_W     = 32;
    localparam int ENEMY_H     = 24;
    localparam int SPACING_X   = 16;
    localparam int SPACING_Y   = 16;
    localparam int SCREEN_W    = 640;
    localparam int START_X     = 64;
    localparam int START_Y     = 48;
    localparam int EDGE_MARGIN = 16;
    localparam int INVADE_Y    = 400;
    localparam int ROWS        = 4;
    localparam int COLS        = 8;
    localparam int STEP_PX     = 2;
    localparam int DROP_PX     = 16;

    localparam int PX = ENEMY_W + SPACING_X;
    localparam int PY = ENEMY_H + SPACING_Y;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MARCH   = 3'd1,
        DROP    = 3'd2,
        CLEARED = 3'd3,
        INVADED = 3'd4
    } formation_state_t;

endpackage

// File: rtl/alien_formation_ctrl_extent.sv
// Combinational extent of the live formation: outermost columns, lowest row, alive count.
module alien_extent #(
    parameter int ROWS = alien_formation_ctrl_pkg::ROWS,
    parameter int COLS = alien_formation_ctrl_pkg::COLS,
    parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int PCW  = $clog2(ROWS * COLS + 1)
) (
    input  logic [ROWS*COLS-1:0] alive_mask,
    output logic [CW-1:0]        lcol,
    output logic [CW-1:0]        rcol,
    output logic [RW-1:0]        brow,
    output logic                 any_alive,
    output logic [PCW-1:0]       popcount
);

    logic [COLS-1:0] w_col_any;
    logic [ROWS-1:0] w_row_any;

    always_comb begin
        w_col_any = '0;
        w_row_any = '0;
        popcount  = '0;
        lcol      = '0;
        rcol      = '0;
        brow      = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_col_any[c] = w_col_any[c] | alive_mask[r*COLS+c];
                w_row_any[r] = w_row_any[r] | alive_mask[r*COLS+c];
                popcount     = popcount + PCW'(alive_mask[r*COLS+c]);
            end
        end
        // Scan directions make the last hit the extreme one.
        for (int c = COLS - 1; c >= 0; c--)
            if (w_col_any[c]) lcol = CW'(c);
        for (int c = 0; c < COLS; c++)
            if (w_col_any[c]) rcol = CW'(c);
        for (int r = 0; r < ROWS; r++)
            if (w_row_any[r]) brow = RW'(r);
    end

    assign any_alive = |alive_mask;

endmodule

// File: rtl/alien_formation_ctrl.sv
// Formation march controller: steps sideways at a speed set by the survivors,
// drops and reverses at screen edges, and flags a cleared or invading wave.
module alien_formation_ctrl #(
    parameter int ROWS    = alien_formation_ctrl_pkg::ROWS,
    parameter int COLS    = alien_formation_ctrl_pkg::COLS,
    parameter int STEP_PX = alien_formation_ctrl_pkg::STEP_PX,
    parameter int DROP_PX = alien_formation_ctrl_pkg::DROP_PX
) (
    input  logic                                       pixel_clk,
    input  logic                                       rst,
    input  logic                                       fsync,
    input  logic                                       start,
    input  logic                                       freeze,
    input  logic [ROWS*COLS-1:0]                       alive_mask,
    output logic signed [11:0]                         group_lhpos,
    output logic signed [11:0]                         group_tvpos,
    output logic [7:0]                                 speed,
    output logic                                       dir_right,
    output logic [5:0]                                 alive_count,
    output logic                                       wave_clear,
    output logic                                       invaded,
    output alien_formation_ctrl_pkg::formation_state_t state
);
    import alien_formation_ctrl_pkg::*;

    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PCW = $clog2(ROWS * COLS + 1);

    logic [CW-1:0]      w_lcol;
    logic [CW-1:0]      w_rcol;
    logic [RW-1:0]      w_brow;
    logic               w_any_alive;
    logic [PCW-1:0]     w_popcount;

    formation_state_t   r_state;
    logic signed [11:0] r_lhpos;
    logic signed [11:0] r_tvpos;
    logic [7:0]         r_speed;
    logic [7:0]         r_frame_cnt;
    logic               r_dir_right;
    logic [5:0]         r_alive_count;
    logic               r_wave_clear;
    logic               r_invaded;

    alien_extent #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .RW(RW), .PCW(PCW)) u_extent (
        .alive_mask (alive_mask),
        .lcol       (w_lcol),
        .rcol       (w_rcol),
        .brow       (w_brow),
        .any_alive  (w_any_alive),
        .popcount   (w_popcount)
    );

    // Edges are evaluated one step ahead, in 13-bit signed so far-left positions compare correctly.
    logic signed [12:0] w_lcol_px, w_rcol_px, w_brow_py;
    logic signed [12:0] w_right_nx, w_left_nx, w_bottom;
    logic               w_hit_right, w_hit_left, w_invade, w_tick;

    assign w_lcol_px   = 13'(w_lcol) * 13'(PX);
    assign w_rcol_px   = 13'(w_rcol) * 13'(PX);
    assign w_brow_py   = 13'(w_brow) * 13'(PY);
    assign w_right_nx  = 13'(r_lhpos) + w_rcol_px + 13'(ENEMY_W - 1 + STEP_PX);
    assign w_left_nx   = 13'(r_lhpos) + w_lcol_px - 13'(STEP_PX);
    assign w_bottom    = 13'(r_tvpos) + w_brow_py + 13'(ENEMY_H - 1);
    assign w_hit_right = w_right_nx > 13'(SCREEN_W - 1 - EDGE_MARGIN);
    assign w_hit_left  = w_left_nx < 13'(EDGE_MARGIN);
    assign w_invade    = w_bottom >= 13'(INVADE_Y);
    assign w_tick      = r_frame_cnt >= (r_speed - 8'd1);

    // fsync is the only strobe: inputs are sampled and every register moves only in its cycle.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_lhpos       <= 12'(START_X);
            r_tvpos       <= 12'(START_Y);
            r_dir_right   <= 1'b1;
            r_frame_cnt   <= '0;
            r_alive_count <= '0;
            r_speed       <= 8'd1;
            r_wave_clear  <= 1'b0;
            r_invaded     <= 1'b0;
        end else if (fsync) begin
            r_alive_count <= 6'(w_popcount);
            r_speed       <= 8'd1 + 8'(w_popcount >> 2);
            if (!freeze) begin
                case (r_state)
                    IDLE, CLEARED, INVADED: begin
                        if (start) begin
                            r_state      <= MARCH;
                            r_lhpos      <= 12'(START_X);
                            r_tvpos      <= 12'(START_Y);
                            r_dir_right  <= 1'b1;
                            r_frame_cnt  <= '0;
                            r_wave_clear <= 1'b0;
                            r_invaded    <= 1'b0;
                        end
                    end
                    MARCH: begin
                        if (!w_any_alive) begin
                            r_state      <= CLEARED;
                            r_wave_clear <= 1'b1;
                        end else if (w_invade) begin
                            r_state   <= INVADED;
                            r_invaded <= 1'b1;
                        end else if (w_tick) begin
                            r_frame_cnt <= '0;
                            if (r_dir_right) begin
                                if (w_hit_right) r_state <= DROP;
                                else             r_lhpos <= r_lhpos + 12'(STEP_PX);
                            end else begin
                                if (w_hit_left)  r_state <= DROP;
                                else             r_lhpos <= r_lhpos - 12'(STEP_PX);
                            end
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end
                    end
                    DROP: begin
                        if (!w_any_alive) begin
                            r_state      <= CLEARED;
                            r_wave_clear <= 1'b1;
                        end else begin
                            r_tvpos     <= r_tvpos + 12'(DROP_PX);
                            r_dir_right <= ~r_dir_right;
                            r_frame_cnt <= '0;
                            r_state     <= MARCH;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign group_lhpos = r_lhpos;
    assign group_tvpos = r_tvpos;
    assign speed       = r_speed;
    assign dir_right   = r_dir_right;
    assign alive_count = r_alive_count;
    assign wave_clear  = r_wave_clear;
    assign invaded     = r_invaded;
    assign state       = r_state;

endmodule

// File: tb/tb_alien_formation_ctrl.sv
// Directed bench for alien_formation_ctrl: every fsync/reset pushes a record, a monitor
// pops one per event and compares the registered outputs a cycle later.
module tb_alien_formation_ctrl;
    import alien_formation_ctrl_pkg::*;

    typedef struct packed {
        logic        chk;
        logic [2:0]  st;
        logic [11:0] lh;
        logic [11:0] tv;
        logic [7:0]  sp;
        logic        dr;
        logic [5:0]  ac;
        logic        wc;
        logic        inv;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    localparam logic [31:0] M_FULL = 32'hFFFF_FFFF;
    localparam logic [31:0] M_HALF = 32'h0000_FFFF;
    localparam logic [31:0] M_COL7 = 32'h8080_8080;
    localparam logic [31:0] M_ROW0 = 32'h0000_0081;

    logic pixel_clk = 1'b0;
    logic rst, fsync, start, freeze;
    logic [31:0] alive_mask;
    logic signed [11:0] group_lhpos, group_tvpos;
    logic [7:0] speed;
    logic dir_right, wave_clear, invaded;
    logic [5:0] alive_count;
    formation_state_t state;

    logic [EXP_W-1:0] exp_q[$];
    string name_q[$];
    int n_total = 0;
    int n_bad = 0;

    alien_formation_ctrl dut (
        .pixel_clk   (pixel_clk),
        .rst         (rst),
        .fsync       (fsync),
        .start       (start),
        .freeze      (freeze),
        .alive_mask  (alive_mask),
        .group_lhpos (group_lhpos),
        .group_tvpos (group_tvpos),
        .speed       (speed),
        .dir_right   (dir_right),
        .alive_count (alive_count),
        .wave_clear  (wave_clear),
        .invaded     (invaded),
        .state       (state)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic push_exp(input bit chk, input string nm, input logic [2:0] st,
                            input int lh, input int tv, input int sp, input logic dr,
                            input int ac, input logic wc, input logic inv);
        exp_t e;
        e.chk = chk; e.st = st; e.lh = 12'(lh); e.tv = 12'(tv); e.sp = 8'(sp);
        e.dr = dr; e.ac = 6'(ac); e.wc = wc; e.inv = inv;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic fr_chk(input logic s, input logic f, input logic [31:0] m, input string nm,
                          input logic [2:0] st, input int lh, input int tv, input int sp,
                          input logic dr, input int ac, input logic wc, input logic inv);
        @(negedge pixel_clk);
        fsync = 1'b1; start = s; freeze = f; alive_mask = m;
        push_exp(1'b1, nm, st, lh, tv, sp, dr, ac, wc, inv);
        @(negedge pixel_clk);
        fsync = 1'b0; start = 1'b0;
    endtask

    task automatic fr_skip(input logic s, input logic f, input logic [31:0] m);
        @(negedge pixel_clk);
        fsync = 1'b1; start = s; freeze = f; alive_mask = m;
        push_exp(1'b0, "", 3'd0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        @(negedge pixel_clk);
        fsync = 1'b0; start = 1'b0;
    endtask

    task automatic fr_run(input int n, input logic f, input logic [31:0] m);
        for (int i = 0; i < n; i++) fr_skip(1'b0, f, m);
    endtask

    task automatic rst_chk(input logic with_fs, input logic [31:0] m, input string nm);
        @(negedge pixel_clk);
        rst = 1'b1; fsync = with_fs; alive_mask = m;
        push_exp(1'b1, nm, IDLE, 64, 48, 1, 1'b1, 0, 1'b0, 1'b0);
        @(negedge pixel_clk);
        rst = 1'b0; fsync = 1'b0;
    endtask

    task automatic check_one();
        exp_t e;
        exp_t g;
        string nm;
        if (exp_q.size() == 0) begin
            n_total++; n_bad++;
            $display("FAIL unexpected_event: DUT event at %0t with nothing queued", $time);
            return;
        end
        e = exp_t'(exp_q.pop_front());
        nm = name_q.pop_front();
        if (!e.chk) return;
        g.chk = 1'b1; g.st = state; g.lh = group_lhpos; g.tv = group_tvpos; g.sp = speed;
        g.dr = dir_right; g.ac = alive_count; g.wc = wave_clear; g.inv = invaded;
        n_total++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s got st=%0d lh=%0d tv=%0d sp=%0d dr=%0b ac=%0d wc=%0b inv=%0b | want st=%0d lh=%0d tv=%0d sp=%0d dr=%0b ac=%0d wc=%0b inv=%0b",
                     nm, g.st, $signed(g.lh), $signed(g.tv), g.sp, g.dr, g.ac, g.wc, g.inv,
                     e.st, $signed(e.lh), $signed(e.tv), e.sp, e.dr, e.ac, e.wc, e.inv);
        end
    endtask

    // Monitor: every reset or fsync edge owns exactly one queued record.
    initial begin
        forever begin
            @(posedge pixel_clk);
            if (fsync || rst) begin
                @(negedge pixel_clk);
                check_one();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; fsync = 1'b0; start = 1'b0; freeze = 1'b0; alive_mask = '0;

        rst_chk(1'b0, '0, "reset");
        fr_chk(0, 0, 32'h0000_000F, "idle_no_start", IDLE, 64, 48, 2, 1, 4, 0, 0);

        // Full formation, first step after 9 frames; start while marching is ignored.
        fr_chk(1, 0, M_FULL, "start", MARCH, 64, 48, 9, 1, 32, 0, 0);
        fr_run(7, 0, M_FULL);
        fr_chk(0, 0, M_FULL, "pre_step", MARCH, 64, 48, 9, 1, 32, 0, 0);
        fr_chk(1, 0, M_FULL, "first_step", MARCH, 66, 48, 9, 1, 32, 0, 0);

        // March to the right limit, drop and reverse.
        fr_run(854, 0, M_FULL);
        fr_chk(0, 0, M_FULL, "right_limit", MARCH, 256, 48, 9, 1, 32, 0, 0);
        fr_run(8, 0, M_FULL);
        fr_chk(0, 0, M_FULL, "enter_drop", DROP, 256, 48, 9, 1, 32, 0, 0);
        fr_chk(0, 0, M_FULL, "drop_done", MARCH, 256, 64, 9, 0, 32, 0, 0);

        // Formation wiped out on a step-tick frame.
        fr_run(8, 0, M_FULL);
        fr_chk(0, 0, '0, "cleared_on_tick", CLEARED, 256, 64, 1, 0, 0, 1, 0);
        fr_chk(0, 0, '0, "cleared_holds", CLEARED, 256, 64, 1, 0, 0, 1, 0);
        fr_chk(1, 0, M_FULL, "restart_cleared", MARCH, 64, 48, 9, 1, 32, 0, 0);

        // Freeze mid-count: nothing moves, alive_count keeps tracking.
        fr_run(4, 0, M_FULL);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0)
                fr_chk(0, 1, M_HALF, $sformatf("freeze%0d", i), MARCH, 64, 48, 5, 1, 16, 0, 0);
            else
                fr_chk(0, 1, M_FULL, $sformatf("freeze%0d", i), MARCH, 64, 48, 9, 1, 32, 0, 0);
        end
        fr_run(3, 0, M_FULL);
        fr_chk(0, 0, M_FULL, "resume_hold", MARCH, 64, 48, 9, 1, 32, 0, 0);
        fr_chk(0, 0, M_FULL, "resume_step", MARCH, 66, 48, 9, 1, 32, 0, 0);

        // Reset beats a coincident fsync mid-march.
        rst_chk(1'b1, M_FULL, "reset_over_fsync");

        // Only column 7 alive: right limit as full, left limit far past the full-width one.
        fr_chk(1, 0, M_COL7, "start_col7", MARCH, 64, 48, 2, 1, 4, 0, 0);
        fr_run(191, 0, M_COL7);
        fr_chk(0, 0, M_COL7, "col7_right_limit", MARCH, 256, 48, 2, 1, 4, 0, 0);
        fr_run(1, 0, M_COL7);
        fr_chk(0, 0, M_COL7, "col7_drop", DROP, 256, 48, 2, 1, 4, 0, 0);
        fr_chk(0, 0, M_COL7, "col7_reverse", MARCH, 256, 64, 2, 0, 4, 0, 0);
        fr_run(245, 0, M_COL7);
        fr_chk(0, 0, M_COL7, "col7_no_early_drop", MARCH, 10, 64, 2, 0, 4, 0, 0);
        fr_run(329, 0, M_COL7);
        fr_chk(0, 0, M_COL7, "col7_left_limit", MARCH, -320, 64, 2, 0, 4, 0, 0);
        fr_run(1, 0, M_COL7);
        fr_chk(0, 0, M_COL7, "col7_left_drop", DROP, -320, 64, 2, 0, 4, 0, 0);
        fr_chk(0, 0, M_COL7, "col7_reverse2", MARCH, -320, 80, 2, 1, 4, 0, 0);

        // Row 0 only (cols 0 and 7, speed 1): bounce until the bottom crosses the invasion line.
        rst_chk(1'b0, '0, "reset_row0");
        fr_chk(1, 0, M_ROW0, "start_row0", MARCH, 64, 48, 1, 1, 2, 0, 0);
        fr_run(97, 0, M_ROW0);
        fr_chk(0, 0, M_ROW0, "row0_drop1", MARCH, 256, 64, 1, 0, 2, 0, 0);
        for (int k = 2; k <= 21; k++) begin
            fr_run(121, 0, M_ROW0);
            fr_chk(0, 0, M_ROW0, $sformatf("row0_drop%0d", k), MARCH,
                   (k % 2 == 1) ? 256 : 16, 48 + 16 * k, 1, (k % 2 == 1) ? 1'b0 : 1'b1, 2, 0, 0);
        end
        fr_chk(0, 0, M_ROW0, "invaded", INVADED, 256, 384, 1, 0, 2, 0, 1);
        fr_chk(0, 0, M_ROW0, "invaded_holds", INVADED, 256, 384, 1, 0, 2, 0, 1);
        fr_chk(1, 0, M_FULL, "restart_invaded", MARCH, 64, 48, 9, 1, 32, 0, 0);
        rst_chk(1'b0, M_FULL, "final_reset");

        repeat (4) @(negedge pixel_clk);
        if (exp_q.size() != 0) begin
            n_total++; n_bad++;
            $display("FAIL leftover_expectations: got %0d queued, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
